booth_div: RTL and testbench

Sequential signed divider: the inverse of the team's `booth_mult`. It divides a 2·width-bit signed dividend, such as a product from `booth_mult`, by a width-bit signed divisor. It returns a width-bit quotient and a width-bit remainder. The core is one radix-2 restoring iteration per clock on operand magnitudes, followed by a sign-correction step. It sits beside `booth_mult` in the arithmetic datapath and uses a start/done handshake.

---
 rtl/booth_div.sv | 134 +++++++++++++
 tb/tb_booth_div.sv | 138 +++++++++++++
 2 files changed

// File: rtl/booth_div.sv
// Sequential signed divider: 2*width-bit dividend by width-bit divisor.
// One restoring iteration per clock on magnitudes, then sign correction.
module booth_div #(
    parameter int width = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*width-1:0]   N,
    input  logic [width-1:0]     D,
    output logic                 busy,
    output logic                 done,
    output logic [width-1:0]     Q,
    output logic [width-1:0]     R,
    output logic                 dbz,
    output logic                 ovf
);
    localparam int CW = $clog2(width) + 1;

    typedef enum logic [2:0] {IDLE, CHECK, CALC, FIX, DONE} state_t;
    state_t state_reg, state_next;

    // acc holds {partial remainder, dividend bits}; quotient bits shift into the low end
    logic [2*width-1:0] acc_reg;
    logic [width-1:0]   dmag_reg;
    logic               sign_q_reg, sign_r_reg;
    logic [CW-1:0]      cnt_reg;
    logic               dbz_flag_reg, ovf_flag_reg;
    logic [width-1:0]   q_res_reg, r_res_reg;
    logic               busy_reg, done_reg, dbz_reg, ovf_reg;
    logic [width-1:0]   q_reg, r_reg;

    logic [2*width-1:0] n_mag;
    logic [width-1:0]   d_mag;
    logic [width-1:0]   acc_hi, qmag;
    logic [width:0]     shifted_hi, trial;
    logic               trial_ok, fix_ovf, early_err;
    logic [2*width-1:0] acc_calc;

    always_comb begin
        n_mag      = N[2*width-1] ? (~N + 1'b1) : N;
        d_mag      = D[width-1]   ? (~D + 1'b1) : D;
        acc_hi     = acc_reg[2*width-1:width];
        qmag       = acc_reg[width-1:0];
        shifted_hi = acc_reg[2*width-1:width-1];
        trial      = shifted_hi - {1'b0, dmag_reg};
        trial_ok   = ~trial[width];
        acc_calc   = {(trial_ok ? trial[width-1:0] : shifted_hi[width-1:0]),
                      acc_reg[width-2:0], trial_ok};
        early_err  = (dmag_reg == '0) || (acc_hi >= dmag_reg);
        // negative results may reach -2^(width-1); positive ones stop one short
        fix_ovf    = sign_q_reg ? (qmag[width-1] & (|qmag[width-2:0])) : qmag[width-1];
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CHECK;
            CHECK:   state_next = early_err ? DONE : CALC;
            CALC:    if (cnt_reg == CW'(width - 1)) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg      <= '0;
            dmag_reg     <= '0;
            sign_q_reg   <= 1'b0;
            sign_r_reg   <= 1'b0;
            cnt_reg      <= '0;
            dbz_flag_reg <= 1'b0;
            ovf_flag_reg <= 1'b0;
            q_res_reg    <= '0;
            r_res_reg    <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            q_reg        <= '0;
            r_reg        <= '0;
            dbz_reg      <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: if (start) begin
                    acc_reg      <= n_mag;
                    dmag_reg     <= d_mag;
                    sign_q_reg   <= N[2*width-1] ^ D[width-1];
                    sign_r_reg   <= N[2*width-1];
                    dbz_flag_reg <= 1'b0;
                    ovf_flag_reg <= 1'b0;
                    busy_reg     <= 1'b1;
                end
                CHECK: begin
                    cnt_reg <= '0;
                    if (dmag_reg == '0)           dbz_flag_reg <= 1'b1;
                    else if (acc_hi >= dmag_reg)  ovf_flag_reg <= 1'b1;
                end
                CALC: begin
                    acc_reg <= acc_calc;
                    cnt_reg <= cnt_reg + 1'b1;
                end
                FIX: begin
                    ovf_flag_reg <= fix_ovf;
                    q_res_reg    <= sign_q_reg ? (~qmag + 1'b1) : qmag;
                    r_res_reg    <= sign_r_reg ? (~acc_hi + 1'b1) : acc_hi;
                end
                DONE: begin
                    done_reg <= 1'b1;
                    busy_reg <= 1'b0;
                    dbz_reg  <= dbz_flag_reg;
                    ovf_reg  <= ovf_flag_reg;
                    q_reg    <= (dbz_flag_reg | ovf_flag_reg) ? '0 : q_res_reg;
                    r_reg    <= (dbz_flag_reg | ovf_flag_reg) ? '0 : r_res_reg;
                end
                default: ;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign Q    = q_reg;
    assign R    = r_reg;
    assign dbz  = dbz_reg;
    assign ovf  = ovf_reg;
endmodule

// File: tb/tb_booth_div.sv
// Directed-vector bench for booth_div (width=8) with hand-computed results.
module tb_booth_div;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [15:0]  n_in;
    logic [7:0]   d_in;
    logic         busy, done, dbz, ovf;
    logic [7:0]   q_out, r_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    booth_div #(.width(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .N     (n_in),
        .D     (d_in),
        .busy  (busy),
        .done  (done),
        .Q     (q_out),
        .R     (r_out),
        .dbz   (dbz),
        .ovf   (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [15:0] n, input logic [7:0] d);
        n_in  = n;
        d_in  = d;
        start = 1'b1;
    endtask

    // Called at the negedge where start was raised; returns at the negedge where done is seen.
    task automatic wait_done(input string tag, input logic [15:0] n, input logic [7:0] d,
                             input logic [7:0] eq, input logic [7:0] er,
                             input logic edbz, input logic eovf,
                             input int elat, input bit disturb);
        int lat = 0;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_run"}, 32'(busy), 32'd1);
        while (!done && lat < 40) begin
            if (disturb) begin
                start = 1'b1;
                n_in  = 16'($urandom);
                d_in  = 8'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_result"}, {14'd0, dbz, ovf, q_out, r_out}, {14'd0, edbz, eovf, eq, er});
        $display("txn %-10s N=0x%04h D=0x%02h -> Q=0x%02h R=0x%02h dbz=%0b ovf=%0b lat=%0d",
                 tag, n, d, q_out, r_out, dbz, ovf, lat);
    endtask

    task automatic run(input string tag, input logic [15:0] n, input logic [7:0] d,
                       input logic [7:0] eq, input logic [7:0] er,
                       input logic edbz, input logic eovf, input int elat);
        @(negedge clk);
        start_op(n, d);
        wait_done(tag, n, d, eq, er, edbz, eovf, elat, 1'b0);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int pulses;
        rst   = 1'b1;
        start = 1'b0;
        n_in  = '0;
        d_in  = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {22'd0, busy, done, dbz, ovf, q_out, r_out}, 32'd0);
        rst = 1'b0;

        run("pos",      16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 11);
        run("neg_n",    16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, 11);
        run("neg_d",    16'h0064, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 11);
        run("neg_both", 16'hFF9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0, 11);
        run("min_q",    16'h4000, 8'h80, 8'h80, 8'h00, 1'b0, 1'b0, 11);
        run("min_q2",   16'hC080, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b0, 11);
        run("fix_ovf",  16'h3F80, 8'h7F, 8'h00, 8'h00, 1'b0, 1'b1, 11);
        run("dbz",      16'h0005, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 2);
        run("chk_ovf",  16'h4000, 8'h40, 8'h00, 8'h00, 1'b0, 1'b1, 2);
        run("min_n",    16'h8000, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1, 2);
        run("small_r",  16'hFFFF, 8'h05, 8'h00, 8'hFF, 1'b0, 1'b0, 11);
        run("zero_n",   16'h0000, 8'hFD, 8'h00, 8'h00, 1'b0, 1'b0, 11);

        // starts and operand changes while busy must be ignored
        @(negedge clk);
        start_op(16'h03E8, 8'hDF);
        wait_done("disturb", 16'h03E8, 8'hDF, 8'hE2, 8'h0A, 1'b0, 1'b0, 11, 1'b1);

        // back-to-back: a start in the done cycle is accepted
        @(negedge clk);
        start_op(16'hFF9C, 8'h07);
        wait_done("b2b_1", 16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, 11, 1'b0);
        start_op(16'h4000, 8'h80);
        wait_done("b2b_2", 16'h4000, 8'h80, 8'h80, 8'h00, 1'b0, 1'b0, 11, 1'b0);

        // reset in the middle of CALC abandons the operation
        @(negedge clk);
        start_op(16'h0064, 8'h07);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset", {22'd0, busy, done, dbz, ovf, q_out, r_out}, 32'd0);
        $display("txn mid_reset busy=%0b done=%0b Q=0x%02h R=0x%02h", busy, done, q_out, r_out);
        rst = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("no_done_after_reset", 32'(pulses), 32'd0);
        run("post_rst", 16'h03E8, 8'hDF, 8'hE2, 8'h0A, 1'b0, 1'b0, 11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
